// File: rtl/phase_unwrap_decimator.sv
// phase_unwrap_decimator
//   Takes the wrapped 32-bit signed phase word from the three-tone
//   phase-noise generator, one sample per clk. It unwraps the phase into an
//   OUT_W = 32 + EXT_W bit running phase. It then emits the mean of each
//   non-overlapping block of 2^LOG2_DEC samples, with a one-cycle strobe.
//
//   Optional feature macro: PHASE_UNWRAP_EN
//     defined   : stage 1 unwraps (running sum of modulo-2^32 differences)
//     undefined : stage 1 just sign-extends the raw phase; wrap_err tied 0
//
// Ports
//   clk             system clock
//   rst             asynchronous active-high reset (deassertion synchronised
//                   upstream)
//   phase           wrapped phase sample, full scale = one cycle
//   phase_valid     phase carries a sample this cycle
//   phase_out       block-mean unwrapped phase, OUT_W signed
//   phase_out_valid one-cycle strobe, phase_out is new
//   wrap_err        sticky: the unwrapped phase overflowed OUT_W signed
module phase_unwrap_decimator #(
    parameter  int LOG2_DEC = 4,
    parameter  int EXT_W    = 16,
    localparam int OUT_W    = 32 + EXT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [31:0]      phase,
    input  logic                    phase_valid,
    output logic signed [OUT_W-1:0] phase_out,
    output logic                    phase_out_valid,
    output logic                    wrap_err
);

    localparam int ACC_W = OUT_W + LOG2_DEC;
    // With LOG2_DEC = 0, keep a 1-bit counter that stays at 0.
    localparam int CNT_W = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_DEC) - 1);

    // ------------------------------------------------------------------
    // Stage 1: unwrap
    // ------------------------------------------------------------------
    logic signed [OUT_W-1:0] unw;
    logic                    s1_valid;

`ifdef PHASE_UNWRAP_EN
    logic signed [31:0]      prev;
    logic signed [31:0]      diff;
    logic signed [OUT_W-1:0] diff_ext;
    logic signed [OUT_W-1:0] unw_next;
    logic                    ovf;

    always_comb begin
        // The 32-bit modulo subtract picks the shortest path around the
        // circle. That is exactly the unwrap step.
        diff     = phase - prev;
        diff_ext = OUT_W'(diff);
        unw_next = unw + diff_ext;
        // Signed overflow: both operands have the same sign, and the sum
        // has the other sign.
        ovf      = (unw[OUT_W-1] == diff_ext[OUT_W-1]) &&
                   (unw_next[OUT_W-1] != unw[OUT_W-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= '0;
            unw      <= '0;
            s1_valid <= 1'b0;
            wrap_err <= 1'b0;
        end else begin
            s1_valid <= phase_valid;
            if (phase_valid) begin
                prev <= phase;
                unw  <= unw_next;   // wraps modulo 2^OUT_W on overflow
                if (ovf)
                    wrap_err <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unw      <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= phase_valid;
            if (phase_valid)
                unw <= OUT_W'(phase);
        end
    end

    assign wrap_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 2: block accumulate and decimate
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] mean;
    logic        [CNT_W-1:0] cnt;

    always_comb begin
        sum  = acc + ACC_W'(unw);
        // The arithmetic shift floors toward -inf. The mean of OUT_W-bit
        // values always fits back into OUT_W bits.
        mean = sum >>> LOG2_DEC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc             <= '0;
            cnt             <= '0;
            phase_out       <= '0;
            phase_out_valid <= 1'b0;
        end else begin
            phase_out_valid <= 1'b0;
            // Idle cycles hold acc/cnt, so gaps never change the result.
            if (s1_valid) begin
                if (cnt == CNT_LAST) begin
                    phase_out       <= mean[OUT_W-1:0];
                    phase_out_valid <= 1'b1;
                    acc             <= '0;
                    cnt             <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_unwrap_decimator.sv
// Directed bench for phase_unwrap_decimator. Five instances cover different
// parameter sets:
//   u0 LOG2_DEC=4, u1 LOG2_DEC=2, u2 LOG2_DEC=3, u3 LOG2_DEC=2/EXT_W=1,
//   u4 LOG2_DEC=0.
// Each expected strobe (value + cycle) is queued when its last sample is
// driven. A negedge monitor pops the entry and compares it.
module tb_phase_unwrap_decimator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] ph [5];
    logic        vl [5];

    logic signed [47:0] po0, po1, po2, po4;
    logic signed [32:0] po3;
    logic ov0, ov1, ov2, ov3, ov4;
    logic we0, we1, we2, we3, we4;

    phase_unwrap_decimator #(.LOG2_DEC(4), .EXT_W(16)) u0 (
        .clk(clk), .rst(rst), .phase(ph[0]), .phase_valid(vl[0]),
        .phase_out(po0), .phase_out_valid(ov0), .wrap_err(we0));
    phase_unwrap_decimator #(.LOG2_DEC(2), .EXT_W(16)) u1 (
        .clk(clk), .rst(rst), .phase(ph[1]), .phase_valid(vl[1]),
        .phase_out(po1), .phase_out_valid(ov1), .wrap_err(we1));
    phase_unwrap_decimator #(.LOG2_DEC(3), .EXT_W(16)) u2 (
        .clk(clk), .rst(rst), .phase(ph[2]), .phase_valid(vl[2]),
        .phase_out(po2), .phase_out_valid(ov2), .wrap_err(we2));
    phase_unwrap_decimator #(.LOG2_DEC(2), .EXT_W(1)) u3 (
        .clk(clk), .rst(rst), .phase(ph[3]), .phase_valid(vl[3]),
        .phase_out(po3), .phase_out_valid(ov3), .wrap_err(we3));
    phase_unwrap_decimator #(.LOG2_DEC(0), .EXT_W(16)) u4 (
        .clk(clk), .rst(rst), .phase(ph[4]), .phase_valid(vl[4]),
        .phase_out(po4), .phase_out_valid(ov4), .wrap_err(we4));

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;

    exp_t q [5][$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int k, input longint v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        q[k].push_back(e);
    endtask

    // Drive one cycle on instance k. Returns the index of the sampling edge.
    task automatic step(input int k, input logic [31:0] p, input logic v,
                        output int e);
        for (int j = 0; j < 5; j++) vl[j] = 1'b0;
        ph[k] = p;
        vl[k] = v;
        @(posedge clk);
        #1;
        e = cyc;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) step(0, 32'd0, 1'b0, e);
    endtask

    task automatic drain_check(input string tag);
        idle(4);
        for (int k = 0; k < 5; k++)
            chk({tag, " missing strobes"}, longint'(q[k].size()), 0);
    endtask

    task automatic do_reset();
        for (int j = 0; j < 5; j++) vl[j] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic   ovs [5];
        longint obs [5];
        exp_t   e;
        ovs = '{ov0, ov1, ov2, ov3, ov4};
        obs = '{longint'(po0), longint'(po1), longint'(po2),
                longint'(po3), longint'(po4)};
        if (!rst) begin
            for (int k = 0; k < 5; k++) begin
                if (ovs[k]) begin
                    n_tests++;
                    assert (q[k].size() != 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_strobe u%0d: got %0d expected none at cyc %0d",
                               k, obs[k], cyc);
                    end
                    if (q[k].size() != 0) begin
                        e = q[k].pop_front();
                        chk($sformatf("u%0d value", k), obs[k], e.val);
                        chk($sformatf("u%0d strobe_cycle", k), longint'(cyc),
                            longint'(e.cyc));
                    end
                end
            end
        end
    end

    initial begin
        int e;
        for (int j = 0; j < 5; j++) begin
            ph[j] = '0;
            vl[j] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset po0", longint'(po0), 0);
        chk("reset ov0", longint'(ov0), 0);
        chk("reset po3", longint'(po3), 0);
        chk("reset we3", longint'(we3), 0);
        rst = 1'b0;
        idle(2);

        // Constant 1000, LOG2_DEC=4: strobes 16 cycles apart
        for (int i = 1; i <= 40; i++) begin
            step(0, 32'd1000, 1'b1, e);
            if (i % 16 == 0) push(0, 1000, e + 1);
        end
        drain_check("const");

        // Wrapped ramp, LOG2_DEC=2
        do_reset();
        step(1, 32'h4000_0000, 1'b1, e);
        step(1, 32'h8000_0000, 1'b1, e);
        step(1, 32'hC000_0000, 1'b1, e);
        step(1, 32'h0000_0000, 1'b1, e);
`ifdef PHASE_UNWRAP_EN
        push(1, 64'sd2684354560, e + 1);
`else
        push(1, -64'sd536870912, e + 1);
`endif
        drain_check("ramp");
        chk("ramp wrap_err", longint'(we1), 0);

        // Gapped valid: 4,8,12,16 with junk during the gaps
        do_reset();
        step(1, 32'd4, 1'b1, e);
        step(1, 32'd777, 1'b0, e);
        step(1, 32'd8, 1'b1, e);
        step(1, 32'd555, 1'b0, e);
        step(1, 32'd12, 1'b1, e);
        step(1, 32'd333, 1'b0, e);
        step(1, 32'd16, 1'b1, e);
        push(1, 10, e + 1);
        step(1, 32'd111, 1'b0, e);
        drain_check("gapped");

        // Mean of -1,0,0,0 floors to -1
        do_reset();
        step(1, 32'hFFFF_FFFF, 1'b1, e);
        step(1, 32'd0, 1'b1, e);
        step(1, 32'd0, 1'b1, e);
        step(1, 32'd0, 1'b1, e);
        push(1, -1, e + 1);
        drain_check("floor");

        // Reset mid-block, LOG2_DEC=3
        do_reset();
        for (int i = 0; i < 5; i++) step(2, 32'd100, 1'b1, e);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            step(2, 32'd200, 1'b1, e);
            if (i == 8) push(2, 200, e + 1);
        end
        drain_check("midreset");

        // LOG2_DEC=0: every sample is an output
        do_reset();
        step(4, 32'hFFFF_FFFB, 1'b1, e);
        push(4, -5, e + 1);
        step(4, 32'd7, 1'b1, e);
        push(4, 7, e + 1);
        drain_check("dec1");

        // Overflow, EXT_W=1: ramp +2^30 per sample
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            logic [31:0] p;
            p = 32'(i) << 30;
            step(3, p, 1'b1, e);
`ifdef PHASE_UNWRAP_EN
            chk($sformatf("ovf wrap_err i=%0d", i), longint'(we3),
                (i >= 4) ? 1 : 0);
            if (i == 4 || i == 12) push(3, 64'sd536870912, e + 1);
            if (i == 8) push(3, -64'sd1610612736, e + 1);
`else
            chk($sformatf("ovf wrap_err i=%0d", i), longint'(we3), 0);
            if (i % 4 == 0) push(3, -64'sd536870912, e + 1);
`endif
        end
        drain_check("ovf");
        do_reset();
        chk("ovf wrap_err cleared", longint'(we3), 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
